// File: rtl/saturn_field_sequencer.sv
// Nibble-serial field sequencer for the Saturn ALU datapath.
// Walks one field of a 64-bit register, one nibble per clock, chaining carry.
module saturn_field_sequencer (
  input  logic       strobe,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] field,
  input  logic [3:0] p_reg,
  input  logic       descend,
  input  logic       carry_init,
  input  logic       alu_carry,
  output logic       busy,
  output logic       nib_valid,
  output logic [3:0] nib_idx,
  output logic       nib_first,
  output logic       nib_last,
  output logic       carry_to_alu,
  output logic       done,
  output logic       carry_out,
  output logic       field_error
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0] state_q, state_d;
  logic [3:0] lo_q, lo_d;
  logic [3:0] hi_q, hi_d;
  logic       desc_q, desc_d;
  logic       cinit_q, cinit_d;
  logic [3:0] idx_q, idx_d;
  logic       first_q, first_d;
  logic       carry_q, carry_d;
  logic       cout_q, cout_d;
  logic       ferr_q, ferr_d;

  logic [3:0] lo_dec, hi_dec;
  logic       legal_dec;
  logic       run, is_last;

  always_comb begin
    lo_dec    = 4'd0;
    hi_dec    = 4'd0;
    legal_dec = 1'b1;
    case (field)
      4'd0:    begin lo_dec = p_reg; hi_dec = p_reg;  end
      4'd1:    begin lo_dec = 4'd0;  hi_dec = p_reg;  end
      4'd2:    begin lo_dec = 4'd2;  hi_dec = 4'd2;   end
      4'd3:    begin lo_dec = 4'd0;  hi_dec = 4'd2;   end
      4'd4:    begin lo_dec = 4'd15; hi_dec = 4'd15;  end
      4'd5:    begin lo_dec = 4'd3;  hi_dec = 4'd14;  end
      4'd6:    begin lo_dec = 4'd0;  hi_dec = 4'd1;   end
      4'd7:    begin lo_dec = 4'd0;  hi_dec = 4'd15;  end
      4'd15:   begin lo_dec = 4'd0;  hi_dec = 4'd4;   end
      default: legal_dec = 1'b0;
    endcase
  end

  assign run     = (state_q == S_RUN);
  assign is_last = desc_q ? (idx_q == lo_q) : (idx_q == hi_q);

  always_comb begin
    state_d = state_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    desc_d  = desc_q;
    cinit_d = cinit_q;
    idx_d   = idx_q;
    first_d = first_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ferr_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && legal_dec) begin
          lo_d    = lo_dec;
          hi_d    = hi_dec;
          desc_d  = descend;
          cinit_d = carry_init;
          idx_d   = descend ? hi_dec : lo_dec;
          first_d = 1'b1;
          state_d = S_RUN;
        end else if (start) begin
          ferr_d = 1'b1;
        end
      end
      S_RUN: begin
        first_d = 1'b0;
        carry_d = alu_carry;
        if (is_last) begin
          cout_d  = alu_carry;
          state_d = S_DONE;
        end else begin
          // Stepping stops at the bound, so the index never wraps.
          idx_d = desc_q ? idx_q - 4'd1 : idx_q + 4'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge strobe or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      lo_q    <= 4'd0;
      hi_q    <= 4'd0;
      desc_q  <= 1'b0;
      cinit_q <= 1'b0;
      idx_q   <= 4'd0;
      first_q <= 1'b0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      desc_q  <= desc_d;
      cinit_q <= cinit_d;
      idx_q   <= idx_d;
      first_q <= first_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ferr_q  <= ferr_d;
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign nib_valid    = run;
  assign nib_idx      = idx_q;
  assign nib_first    = run & first_q;
  assign nib_last     = run & is_last;
  assign carry_to_alu = run & (first_q ? cinit_q : carry_q);
  assign done         = (state_q == S_DONE);
  assign carry_out    = cout_q;
  assign field_error  = ferr_q;

endmodule
